// File: rtl/mult_sequencer.sv
// Sequential shift-add unsigned multiplier with MULT / MULTPLUS / CLEAR operations.
// Holds the pipeline via stall_o while a multiply is requested or in progress.
module mult_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       operation_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OpMult     = 2'b00;
  localparam logic [1:0] OpMultPlus = 2'b01;
  localparam logic [1:0] OpClear    = 2'b10;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [2*WIDTH-1:0]   acc_sum;
  logic                 last_iter;
  logic                 mul_req;

  // Accumulator including the current multiplier bit, so the final iteration
  // can be committed straight into {HI,LO}.
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_iter = (cnt_q == CntW'(WIDTH - 1));
  assign mul_req   = start_i & ((operation_i == OpMult) | (operation_i == OpMultPlus));

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    prod_d   = prod_q;

    unique case (state_q)
      StIdle: begin
        if (mul_req) begin
          mcand_d  = {{WIDTH{1'b0}}, operand_a_i};
          mplier_d = operand_b_i;
          op_d     = operation_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end else if (start_i && (operation_i == OpClear)) begin
          prod_d = '0;
        end
      end
      StRun: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (last_iter) begin
          state_d = StDone;
          // MULTPLUS wraps modulo 2^(2*WIDTH); carry out is dropped.
          prod_d  = (op_q == OpMultPlus) ? (prod_q + acc_sum) : acc_sum;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      prod_q   <= prod_d;
    end
  end

  assign hi_o    = prod_q[2*WIDTH-1:WIDTH];
  assign lo_o    = prod_q[WIDTH-1:0];
  assign busy_o  = (state_q == StRun);
  assign done_o  = (state_q == StDone);
  assign stall_o = (state_q == StRun) | ((state_q == StIdle) & mul_req);

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: table of operations with hand-computed
// results, plus sequences for ignored restarts and mid-run reset.
module tb_mult_sequencer;

  localparam int unsigned WIDTH = 32;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [1:0]  operation_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        done_o;
  logic        stall_o;

  int          checks;
  int          errors;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;
  vec_t        vecs[13];

  mult_sequencer #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .operation_i (operation_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .stall_o     (stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int busy_cnt;
    @(negedge clk_i);
    start_i     = 1'b1;
    operation_i = v.op;
    operand_a_i = v.a;
    operand_b_i = v.b;
    #1;
    chk($sformatf("stall_req[%0d]", idx), 64'(stall_o), 64'(v.op < 2'd2));
    @(posedge clk_i);
    #1;
    // Garbage on the inputs during RUN must be ignored.
    start_i     = 1'b0;
    operation_i = 2'b10;
    operand_a_i = $urandom;
    operand_b_i = $urandom;
    if (v.op < 2'd2) begin
      busy_cnt = 0;
      for (int c = 0; c < int'(WIDTH) + 5 && busy_o; c++) begin
        busy_cnt++;
        if (c == int'(WIDTH) / 2) begin
          chk($sformatf("hold_hilo[%0d]", idx), {hi_o, lo_o}, {prev_hi, prev_lo});
          chk($sformatf("stall_run[%0d]", idx), 64'(stall_o), 64'(1));
        end
        @(posedge clk_i);
        #1;
      end
      chk($sformatf("busy_cycles[%0d]", idx), 64'(busy_cnt), 64'(WIDTH));
      chk($sformatf("done[%0d]", idx), 64'(done_o), 64'(1));
      chk($sformatf("stall_done[%0d]", idx), 64'(stall_o), 64'(0));
    end else begin
      chk($sformatf("busy_idle[%0d]", idx), 64'({busy_o, done_o}), 64'(0));
    end
    chk($sformatf("hilo[%0d]", idx), {hi_o, lo_o}, {v.exp_hi, v.exp_lo});
    if (v.op < 2'd2) begin
      @(posedge clk_i);
      #1;
      chk($sformatf("done_pulse[%0d]", idx), 64'({busy_o, done_o}), 64'(0));
    end
    operation_i = 2'b00;
    prev_hi = v.exp_hi;
    prev_lo = v.exp_lo;
  endtask

  initial begin
    int   busy_tot;
    int   done_cnt;
    vec_t v;

    vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'h00000000, 32'h0000002A};
    vecs[1]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{2'b01, 32'd2,          32'd2,          32'hFFFFFFFE, 32'h00000005};
    vecs[3]  = '{2'b10, 32'd9,          32'd9,          32'h00000000, 32'h00000000};
    vecs[4]  = '{2'b00, 32'h00010000,   32'h00010000,   32'h00000001, 32'h00000000};
    vecs[5]  = '{2'b01, 32'hFFFFFFFF,   32'd1,          32'h00000001, 32'hFFFFFFFF};
    vecs[6]  = '{2'b11, 32'd5,          32'd5,          32'h00000001, 32'hFFFFFFFF};
    vecs[7]  = '{2'b00, 32'd0,          32'hDEADBEEF,   32'h00000000, 32'h00000000};
    vecs[8]  = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001};
    vecs[9]  = '{2'b01, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[10] = '{2'b01, 32'd1,          32'd1,          32'h00000000, 32'h00000000};
    vecs[11] = '{2'b00, 32'h12345678,   32'h00000010,   32'h00000001, 32'h23456780};
    vecs[12] = '{2'b01, 32'h80000000,   32'd2,          32'h00000002, 32'h23456780};

    checks      = 0;
    errors      = 0;
    prev_hi     = '0;
    prev_lo     = '0;
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    operation_i = 2'b00;
    operand_a_i = '0;
    operand_b_i = '0;

    #22;
    chk("reset_outputs", 64'({hi_o, lo_o, busy_o, done_o, stall_o} == '0), 64'(1));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_reset_hilo", {hi_o, lo_o}, 64'(0));
    chk("post_reset_ctrl", 64'({busy_o, done_o, stall_o}), 64'(0));

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Restart during RUN and during DONE must be dropped.
    @(negedge clk_i);
    start_i     = 1'b1;
    operation_i = 2'b00;
    operand_a_i = 32'd3;
    operand_b_i = 32'd5;
    @(posedge clk_i);
    #1;
    start_i     = 1'b0;
    operand_a_i = '0;
    operand_b_i = '0;
    busy_tot    = busy_o ? 1 : 0;
    done_cnt    = 0;
    for (int c = 1; c < 45; c++) begin
      if (c == 4) begin
        start_i     = 1'b1;
        operand_a_i = 32'd9;
        operand_b_i = 32'd9;
      end
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      if (busy_o) busy_tot++;
      if (done_o) begin
        done_cnt++;
        start_i     = 1'b1;
        operand_a_i = 32'd9;
        operand_b_i = 32'd9;
      end
    end
    start_i = 1'b0;
    chk("restart_busy_total", 64'(busy_tot), 64'(WIDTH));
    chk("restart_done_count", 64'(done_cnt), 64'(1));
    chk("restart_hilo", {hi_o, lo_o}, 64'h0000_0000_0000_000F);
    chk("restart_idle", 64'({busy_o, done_o}), 64'(0));

    // Reset in the middle of a RUN discards everything.
    @(negedge clk_i);
    start_i     = 1'b1;
    operation_i = 2'b00;
    operand_a_i = 32'h0000FFFF;
    operand_b_i = 32'h0000FFFF;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midrun_reset_hilo", {hi_o, lo_o}, 64'(0));
    chk("midrun_reset_ctrl", 64'({busy_o, done_o, stall_o}), 64'(0));
    @(posedge clk_i);
    #1;
    rst_ni  = 1'b1;
    prev_hi = '0;
    prev_lo = '0;
    v = '{2'b00, 32'd7, 32'd6, 32'h00000000, 32'h0000002A};
    run_vec(100, v);
    v = '{2'b10, 32'd0, 32'd0, 32'h00000000, 32'h00000000};
    run_vec(101, v);
    #1;
    chk("final_stall", 64'(stall_o), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
